// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 output conditioning stage:
// FSM state encoding and panel bus widths.
package hub75_pkg;

  localparam int HUB75_ROW_WIDTH = 4;
  localparam int HUB75_RGB_WIDTH = 3;

  typedef enum logic [1:0] {
    PASS      = 2'd0,
    PRE_BLANK = 2'd1,
    SWITCH    = 2'd2,
    SETTLE    = 2'd3
  } hub75_state_e;

endpackage

// File: rtl/hub75_pin_register.sv
// One aligned register stage for the pixel-side HUB75 pins (rgb, pixel clock, latch).
// Runs unconditionally so data timing never depends on the row-switch FSM.
module hub75_pin_register
  import hub75_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [HUB75_RGB_WIDTH-1:0] rgb1_d,
  input  logic [HUB75_RGB_WIDTH-1:0] rgb2_d,
  input  logic                       clk_pixel_d,
  input  logic                       row_latch_d,
  output logic [HUB75_RGB_WIDTH-1:0] rgb1_q,
  output logic [HUB75_RGB_WIDTH-1:0] rgb2_q,
  output logic                       clk_pixel_q,
  output logic                       row_latch_q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb1_q      <= '0;
      rgb2_q      <= '0;
      clk_pixel_q <= 1'b0;
      row_latch_q <= 1'b0;
    end else begin
      rgb1_q      <= rgb1_d;
      rgb2_q      <= rgb2_d;
      clk_pixel_q <= clk_pixel_d;
      row_latch_q <= row_latch_d;
    end
  end

endmodule

// File: rtl/hub75_row_deghost.sv
// HUB75 output stage: registers all panel pins and blanks #OE around every
// row-address change (pre-blank, switch, settle) to hide address-line skew.
module hub75_row_deghost
  import hub75_pkg::*;
#(
  parameter int                     TICKS_WIDTH      = 4,
  parameter logic [TICKS_WIDTH-1:0] BLANK_PRE_TICKS  = 4'd2,
  parameter logic [TICKS_WIDTH-1:0] ROW_SETTLE_TICKS = 4'd4
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic [HUB75_ROW_WIDTH-1:0] row_address_in,
  input  logic                       output_enable_in,
  input  logic                       row_latch_in,
  input  logic                       clk_pixel_in,
  input  logic [HUB75_RGB_WIDTH-1:0] rgb1_in,
  input  logic [HUB75_RGB_WIDTH-1:0] rgb2_in,
  output logic [HUB75_ROW_WIDTH-1:0] row_address_out,
  output logic                       oe_n_out,
  output logic                       row_latch_out,
  output logic                       clk_pixel_out,
  output logic [HUB75_RGB_WIDTH-1:0] rgb1_out,
  output logic [HUB75_RGB_WIDTH-1:0] rgb2_out,
  output logic                       blanking,
  output logic [7:0]                 row_switch_count,
  output hub75_state_e               state
);

  localparam logic [TICKS_WIDTH-1:0] TICK_ONE = {{(TICKS_WIDTH-1){1'b0}}, 1'b1};

  logic [TICKS_WIDTH-1:0] counter;
  logic                   row_changed;

  assign row_changed = (row_address_in != row_address_out);

  hub75_pin_register u_pin_register (
    .clk         (clk_in),
    .reset       (reset),
    .rgb1_d      (rgb1_in),
    .rgb2_d      (rgb2_in),
    .clk_pixel_d (clk_pixel_in),
    .row_latch_d (row_latch_in),
    .rgb1_q      (rgb1_out),
    .rgb2_q      (rgb2_out),
    .clk_pixel_q (clk_pixel_out),
    .row_latch_q (row_latch_out)
  );

  // oe_n_out and blanking are forced high on every edge taken outside PASS,
  // including the edge that returns to PASS; enable resumes one edge later.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state            <= PASS;
      counter          <= '0;
      oe_n_out         <= 1'b1;
      row_address_out  <= '0;
      blanking         <= 1'b0;
      row_switch_count <= '0;
    end else begin
      case (state)
        PASS: begin
          if (row_changed) begin
            oe_n_out <= 1'b1;
            blanking <= 1'b1;
            if (BLANK_PRE_TICKS == '0) begin
              state   <= SWITCH;
              counter <= '0;
            end else begin
              state   <= PRE_BLANK;
              counter <= BLANK_PRE_TICKS;
            end
          end else begin
            oe_n_out <= ~output_enable_in;
            blanking <= 1'b0;
          end
        end

        PRE_BLANK: begin
          oe_n_out <= 1'b1;
          blanking <= 1'b1;
          if (counter <= TICK_ONE) begin
            state   <= SWITCH;
            counter <= '0;
          end else begin
            counter <= counter - TICK_ONE;
          end
        end

        SWITCH: begin
          oe_n_out        <= 1'b1;
          blanking        <= 1'b1;
          row_address_out <= row_address_in;
          if (row_switch_count != 8'hFF) begin
            row_switch_count <= row_switch_count + 8'd1;
          end
          if (ROW_SETTLE_TICKS == '0) begin
            state   <= PASS;
            counter <= '0;
          end else begin
            state   <= SETTLE;
            counter <= ROW_SETTLE_TICKS;
          end
        end

        SETTLE: begin
          oe_n_out <= 1'b1;
          blanking <= 1'b1;
          // A fresh request while settling restarts the whole blank sequence.
          if (row_changed) begin
            if (BLANK_PRE_TICKS == '0) begin
              state   <= SWITCH;
              counter <= '0;
            end else begin
              state   <= PRE_BLANK;
              counter <= BLANK_PRE_TICKS;
            end
          end else if (counter <= TICK_ONE) begin
            state   <= PASS;
            counter <= '0;
          end else begin
            counter <= counter - TICK_ONE;
          end
        end

        default: begin
          state    <= PASS;
          counter  <= '0;
          oe_n_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_row_deghost.sv
// Bench for hub75_row_deghost: default-timing instance (dut0) and a
// zero pre-blank/settle instance (dut1) sharing clock, reset and inputs.
module tb_hub75_row_deghost;
  import hub75_pkg::*;

  logic       clk_in = 1'b0;
  logic       reset;
  logic [3:0] row_address_in;
  logic       output_enable_in;
  logic       row_latch_in;
  logic       clk_pixel_in;
  logic [2:0] rgb1_in;
  logic [2:0] rgb2_in;

  logic [3:0]   row0, row1;
  logic         oe_n0, oe_n1;
  logic         latch0, latch1;
  logic         clkp0, clkp1;
  logic [2:0]   rgb1_0, rgb1_1, rgb2_0, rgb2_1;
  logic         blank0, blank1;
  logic [7:0]   count0, count1;
  hub75_state_e state0, state1;

  int checks   = 0;
  int failures = 0;
  int exp_count0 = 0;
  int exp_count1 = 0;

  // {blanking, oe_n_out, row_address_out}
  logic [5:0] exp_q[$];
  logic [5:0] exp;
  // {row_latch, clk_pixel, rgb2, rgb1}
  logic [7:0] pin_q[$];
  logic [7:0] pexp;

  always #5 clk_in = ~clk_in;

  hub75_row_deghost dut0 (
    .clk_in           (clk_in),
    .reset            (reset),
    .row_address_in   (row_address_in),
    .output_enable_in (output_enable_in),
    .row_latch_in     (row_latch_in),
    .clk_pixel_in     (clk_pixel_in),
    .rgb1_in          (rgb1_in),
    .rgb2_in          (rgb2_in),
    .row_address_out  (row0),
    .oe_n_out         (oe_n0),
    .row_latch_out    (latch0),
    .clk_pixel_out    (clkp0),
    .rgb1_out         (rgb1_0),
    .rgb2_out         (rgb2_0),
    .blanking         (blank0),
    .row_switch_count (count0),
    .state            (state0)
  );

  hub75_row_deghost #(
    .TICKS_WIDTH      (4),
    .BLANK_PRE_TICKS  (4'd0),
    .ROW_SETTLE_TICKS (4'd0)
  ) dut1 (
    .clk_in           (clk_in),
    .reset            (reset),
    .row_address_in   (row_address_in),
    .output_enable_in (output_enable_in),
    .row_latch_in     (row_latch_in),
    .clk_pixel_in     (clk_pixel_in),
    .rgb1_in          (rgb1_in),
    .rgb2_in          (rgb2_in),
    .row_address_out  (row1),
    .oe_n_out         (oe_n1),
    .row_latch_out    (latch1),
    .clk_pixel_out    (clkp1),
    .rgb1_out         (rgb1_1),
    .rgb2_out         (rgb2_1),
    .blanking         (blank1),
    .row_switch_count (count1),
    .state            (state1)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    row_address_in = 4'd0;
    output_enable_in = 1'b1;
    row_latch_in = 1'b0;
    clk_pixel_in = 1'b0;
    rgb1_in = 3'd0;
    rgb2_in = 3'd0;
    tick();
    tick();
    checks++;
    if (oe_n0 !== 1'b1) begin failures++; $display("FAIL reset_oe_n got=%0b exp=1", oe_n0); end
    checks++;
    if (row0 !== 4'd0) begin failures++; $display("FAIL reset_row got=%0d exp=0", row0); end
    checks++;
    if (count0 !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count0); end
    checks++;
    if (blank0 !== 1'b0) begin failures++; $display("FAIL reset_blanking got=%0b exp=0", blank0); end
    checks++;
    if (state0 !== PASS) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state0, PASS); end
    checks++;
    if ({latch0, clkp0, rgb2_0, rgb1_0} !== 8'd0) begin
      failures++; $display("FAIL reset_pins got=%b exp=0", {latch0, clkp0, rgb2_0, rgb1_0});
    end
    reset = 1'b1;
    tick();
    checks++;
    if (oe_n0 !== 1'b0) begin failures++; $display("FAIL release_oe_n got=%0b exp=0", oe_n0); end
    checks++;
    if (oe_n1 !== 1'b0) begin failures++; $display("FAIL release_oe_n_zero got=%0b exp=0", oe_n1); end
    checks++;
    if (row0 !== 4'd0 || count0 !== 8'd0) begin
      failures++; $display("FAIL release_row_count got=%0d/%0d exp=0/0", row0, count0);
    end
  endtask

  task automatic test_row_switch();
    for (int k = 0; k <= 8; k++)
      exp_q.push_back({(k <= 7) ? 1'b1 : 1'b0, (k <= 7) ? 1'b1 : 1'b0, (k >= 3) ? 4'd5 : 4'd0});
    for (int k = 0; k <= 8; k++) begin
      row_address_in = 4'd5;
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({blank0, oe_n0, row0} !== exp) begin
        failures++; $display("FAIL row_switch k=%0d got=%b exp=%b", k, {blank0, oe_n0, row0}, exp);
      end
    end
    exp_count0++;
    exp_count1++;
    checks++;
    if (count0 !== exp_count0[7:0]) begin
      failures++; $display("FAIL row_switch_count got=%0d exp=%0d", count0, exp_count0);
    end
  endtask

  task automatic test_pre_blank_update();
    for (int k = 0; k <= 8; k++)
      exp_q.push_back({(k <= 7) ? 1'b1 : 1'b0, (k <= 7) ? 1'b1 : 1'b0, (k >= 3) ? 4'd7 : 4'd5});
    for (int k = 0; k <= 8; k++) begin
      row_address_in = (k == 0) ? 4'd6 : 4'd7;
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({blank0, oe_n0, row0} !== exp) begin
        failures++; $display("FAIL pre_blank_update k=%0d got=%b exp=%b", k, {blank0, oe_n0, row0}, exp);
      end
    end
    exp_count0++;
    exp_count1++;
    checks++;
    if (count0 !== exp_count0[7:0]) begin
      failures++; $display("FAIL pre_blank_count got=%0d exp=%0d", count0, exp_count0);
    end
  endtask

  task automatic test_settle_restart();
    for (int k = 0; k <= 13; k++)
      exp_q.push_back({(k <= 12) ? 1'b1 : 1'b0, (k <= 12) ? 1'b1 : 1'b0,
                       (k < 3) ? 4'd7 : ((k < 8) ? 4'd10 : 4'd8)});
    for (int k = 0; k <= 13; k++) begin
      row_address_in = (k < 5) ? 4'd10 : 4'd8;
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({blank0, oe_n0, row0} !== exp) begin
        failures++; $display("FAIL settle_restart k=%0d got=%b exp=%b", k, {blank0, oe_n0, row0}, exp);
      end
    end
    exp_count0 += 2;
    exp_count1 += 2;
    checks++;
    if (count0 !== exp_count0[7:0]) begin
      failures++; $display("FAIL settle_restart_count got=%0d exp=%0d", count0, exp_count0);
    end
  endtask

  task automatic test_row_back();
    for (int k = 0; k <= 8; k++)
      exp_q.push_back({(k <= 7) ? 1'b1 : 1'b0, (k <= 7) ? 1'b1 : 1'b0, 4'd8});
    for (int k = 0; k <= 8; k++) begin
      row_address_in = (k == 0) ? 4'd2 : 4'd8;
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({blank0, oe_n0, row0} !== exp) begin
        failures++; $display("FAIL row_back k=%0d got=%b exp=%b", k, {blank0, oe_n0, row0}, exp);
      end
    end
    exp_count0++;
    exp_count1++;
    checks++;
    if (count0 !== exp_count0[7:0]) begin
      failures++; $display("FAIL row_back_count got=%0d exp=%0d", count0, exp_count0);
    end
  endtask

  task automatic test_zero_params();
    exp_q.push_back({1'b1, 1'b1, 4'd8});
    exp_q.push_back({1'b1, 1'b1, 4'd1});
    exp_q.push_back({1'b0, 1'b0, 4'd1});
    for (int k = 0; k <= 2; k++) begin
      row_address_in = 4'd1;
      rgb1_in = (k == 0) ? 3'b101 : 3'b010;
      pin_q.push_back({row_latch_in, clk_pixel_in, rgb2_in, rgb1_in});
      tick();
      exp = exp_q.pop_front();
      pexp = pin_q.pop_front();
      checks++;
      if ({blank1, oe_n1, row1} !== exp) begin
        failures++; $display("FAIL zero_params k=%0d got=%b exp=%b", k, {blank1, oe_n1, row1}, exp);
      end
      checks++;
      if (rgb1_0 !== pexp[2:0] || rgb1_1 !== pexp[2:0]) begin
        failures++; $display("FAIL zero_params_rgb1 k=%0d got=%b/%b exp=%b", k, rgb1_0, rgb1_1, pexp[2:0]);
      end
    end
    exp_count1++;
    checks++;
    if (count1 !== exp_count1[7:0]) begin
      failures++; $display("FAIL zero_params_count got=%0d exp=%0d", count1, exp_count1);
    end
  endtask

  task automatic test_data_path();
    for (int k = 0; k < 20; k++) begin
      rgb1_in      = 3'($urandom_range(0, 7));
      rgb2_in      = 3'($urandom_range(0, 7));
      clk_pixel_in = 1'($urandom_range(0, 1));
      row_latch_in = 1'($urandom_range(0, 1));
      pin_q.push_back({row_latch_in, clk_pixel_in, rgb2_in, rgb1_in});
      tick();
      pexp = pin_q.pop_front();
      checks++;
      if ({latch0, clkp0, rgb2_0, rgb1_0} !== pexp || {latch1, clkp1, rgb2_1, rgb1_1} !== pexp) begin
        failures++;
        $display("FAIL data_path k=%0d got=%b/%b exp=%b", k,
                 {latch0, clkp0, rgb2_0, rgb1_0}, {latch1, clkp1, rgb2_1, rgb1_1}, pexp);
      end
    end
    checks++;
    if (state0 !== PASS || row0 !== 4'd1) begin
      failures++; $display("FAIL data_path_settled got=%0d/%0d exp=%0d/1", state0, row0, PASS);
    end
  endtask

  task automatic test_reset_and_saturate();
    row_address_in = 4'd4;
    repeat (5) tick();
    checks++;
    if (state0 !== SETTLE) begin failures++; $display("FAIL mid_settle_state got=%0d exp=%0d", state0, SETTLE); end
    reset = 1'b0;
    #1;
    checks++;
    if (oe_n0 !== 1'b1) begin failures++; $display("FAIL mid_reset_oe_n got=%0b exp=1", oe_n0); end
    checks++;
    if (row0 !== 4'd0) begin failures++; $display("FAIL mid_reset_row got=%0d exp=0", row0); end
    checks++;
    if (state0 !== PASS) begin failures++; $display("FAIL mid_reset_state got=%0d exp=%0d", state0, PASS); end
    checks++;
    if (count0 !== 8'd0 || blank0 !== 1'b0) begin
      failures++; $display("FAIL mid_reset_count_blank got=%0d/%0b exp=0/0", count0, blank0);
    end
    row_address_in = 4'd0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 300; i++) begin
      row_address_in = i[0] ? 4'd0 : 4'd12;
      repeat (9) tick();
      if (i == 99) begin
        checks++;
        if (count0 !== 8'd100) begin failures++; $display("FAIL count_100 got=%0d exp=100", count0); end
      end
    end
    checks++;
    if (count0 !== 8'd255 || count1 !== 8'd255) begin
      failures++; $display("FAIL count_saturate got=%0d/%0d exp=255/255", count0, count1);
    end
    checks++;
    if (row0 !== 4'd0 || oe_n0 !== 1'b0) begin
      failures++; $display("FAIL after_saturate got=%0d/%0b exp=0/0", row0, oe_n0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_row_switch();
    test_pre_blank_update();
    test_settle_restart();
    test_row_back();
    test_zero_params();
    test_data_path();
    test_reset_and_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
